// File: rtl/loop_ctrl.sv
// Bracket/loop controller feeding the return-address stack.
// Pushes loop-start PCs on '[', pops on loop exit, requests a jump back to
// the loop body on ']' with a non-zero cell, and runs a forward-skip mode
// (with a nesting counter) when '[' sees a zero cell.
module loop_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 16,
   parameter int NEST_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       op_valid,
   input  logic [1:0]                 op_code,
   output logic                       op_ready,
   input  logic [ADDR_W-1:0]          pc,
   input  logic                       cell_zero,
   output logic                       stk_we,
   output logic [1:0]                 stk_delta,
   output logic [ADDR_W-1:0]          stk_wd,
   input  logic [ADDR_W-1:0]          stk_rd,
   output logic                       jump,
   output logic [ADDR_W-1:0]          jump_pc,
   output logic                       skipping,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       err
);

   localparam int DW = $clog2(DEPTH + 1);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_SKIP  = 2'd1;
   localparam logic [1:0] ST_JUMP  = 2'd2;
   localparam logic [1:0] ST_ERROR = 2'd3;

   localparam logic [1:0] OP_OPEN  = 2'b01;
   localparam logic [1:0] OP_CLOSE = 2'b10;

   localparam logic [1:0] DELTA_HOLD = 2'b00;
   localparam logic [1:0] DELTA_PUSH = 2'b01;
   localparam logic [1:0] DELTA_POP  = 2'b11;

   localparam logic [DW-1:0]     DEPTH_FULL = DW'(DEPTH);
   localparam logic [NEST_W-1:0] NEST_MAX   = '1;

   logic [1:0]        state_reg, state_next;
   logic [DW-1:0]     depth_reg, depth_next;
   logic [NEST_W-1:0] nest_reg, nest_next;
   logic [ADDR_W-1:0] jump_pc_reg, jump_pc_next;
   logic              err_reg, err_next;

   // Outputs decoded directly from registered state, so rst clears them at once
   assign op_ready = (state_reg == ST_RUN) || (state_reg == ST_SKIP);
   assign jump     = (state_reg == ST_JUMP);
   assign skipping = (state_reg == ST_SKIP);
   assign jump_pc  = jump_pc_reg;
   assign depth    = depth_reg;
   assign err      = err_reg;

   // Next-state and stack-command decode; stack acts on the acceptance edge
   always_comb begin
      state_next   = state_reg;
      depth_next   = depth_reg;
      nest_next    = nest_reg;
      jump_pc_next = jump_pc_reg;
      err_next     = err_reg;
      stk_we       = 1'b0;
      stk_delta    = DELTA_HOLD;
      stk_wd       = '0;

      case (state_reg)
         ST_RUN: begin
            if (op_valid) begin
               if (op_code == OP_OPEN) begin
                  if (cell_zero) begin
                     // Zero cell: skip forward to the matching ']'
                     nest_next  = '0;
                     state_next = ST_SKIP;
                  end else if (depth_reg == DEPTH_FULL) begin
                     err_next   = 1'b1;
                     state_next = ST_ERROR;
                  end else begin
                     stk_we     = 1'b1;
                     stk_delta  = DELTA_PUSH;
                     stk_wd     = pc;
                     depth_next = depth_reg + DW'(1);
                  end
               end else if (op_code == OP_CLOSE) begin
                  if (depth_reg == '0) begin
                     err_next   = 1'b1;
                     state_next = ST_ERROR;
                  end else if (cell_zero) begin
                     // Loop exit: discard the saved loop start
                     stk_delta  = DELTA_POP;
                     depth_next = depth_reg - DW'(1);
                  end else begin
                     // Loop again: resume at the op after the matching '['
                     jump_pc_next = stk_rd + ADDR_W'(1);
                     state_next   = ST_JUMP;
                  end
               end
            end
         end
         ST_SKIP: begin
            if (op_valid) begin
               if (op_code == OP_OPEN) begin
                  if (nest_reg == NEST_MAX) begin
                     err_next   = 1'b1;
                     state_next = ST_ERROR;
                  end else begin
                     nest_next = nest_reg + NEST_W'(1);
                  end
               end else if (op_code == OP_CLOSE) begin
                  if (nest_reg == '0) begin
                     state_next = ST_RUN;
                  end else begin
                     nest_next = nest_reg - NEST_W'(1);
                  end
               end
            end
         end
         ST_JUMP: begin
            state_next = ST_RUN;
         end
         default: begin
            // ERROR is terminal until reset
            err_next = 1'b1;
         end
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_RUN;
         depth_reg   <= '0;
         nest_reg    <= '0;
         jump_pc_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         depth_reg   <= depth_next;
         nest_reg    <= nest_next;
         jump_pc_reg <= jump_pc_next;
         err_reg     <= err_next;
      end
   end

endmodule

// File: doc/loop_ctrl.md
Name: loop_ctrl

Overview:
Bracket/loop controller that sits directly upstream of the return-address stack and drives its we/delta/wd ports. It accepts decoded '[' / ']' ops from the sequencer together with the current PC and data-cell zero flag. It pushes loop-start addresses, pops on loop exit and issues jump requests. It also runs forward-skip mode, with a nesting counter, when '[' sees a zero cell.

Parameters:
ADDR_W, 16, PC width; equals the stack WIDTH.
DEPTH, 16, stack capacity in entries; equals the stack DEPTH.
NEST_W, 8, width of the skip-mode nesting counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
op_valid  in  1  sequencer presents an op this cycle.
op_code  in  2  00 = other, 01 = '[', 10 = ']', 11 = other.
op_ready  out  1  op accepted when op_valid & op_ready.
pc  in  ADDR_W  address of the presented op.
cell_zero  in  1  current data cell == 0; sampled at acceptance.
stk_we  out  1  to stack we.
stk_delta  out  2  to stack delta: 00 = hold, 01 = push, 11 = pop.
stk_wd  out  ADDR_W  to stack wd.
stk_rd  in  ADDR_W  stack top (head).
jump  out  1  one-cycle pulse: sequencer loads jump_pc.
jump_pc  out  ADDR_W  jump target, valid while jump = 1.
skipping  out  1  high in SKIP; sequencer suppresses data ops.
depth  out  clog2(DEPTH+1)  current stack occupancy.
err  out  1  sticky error: overflow, underflow or nest overflow.

Behaviour:
- Reset (async): state = RUN, depth = 0, nest = 0, jump = 0, jump_pc = 0, err = 0. All stack outputs are 0 (hold); stack contents are not cleared.
- States: RUN, SKIP, JUMP, ERROR.
- op_ready = 1 in RUN and SKIP; 0 in JUMP and ERROR.
- stk_we, stk_delta and stk_wd are combinational from the accepted op, so the stack updates on the same edge as acceptance. The default is hold.
- RUN, '[' with cell_zero = 0:
  - if depth == DEPTH: set err, go to ERROR, no push.
  - else push (stk_we = 1, delta = 01, wd = pc) and depth += 1.
- RUN, '[' with cell_zero = 1: no push; nest = 0; go to SKIP.
- RUN, ']' with depth == 0: set err, go to ERROR, no stack action.
- RUN, ']' with cell_zero = 1: pop (delta = 11, we = 0) and depth -= 1. No jump.
- RUN, ']' with cell_zero = 0: no stack action. Register jump_pc = stk_rd + 1 (mod 2^ADDR_W) and go to JUMP.
- RUN, other op: accepted, no action.
- JUMP: jump = 1 for exactly one cycle, then RUN. An op offered in this cycle is not accepted.
- SKIP (skipping = 1), all ops are accepted and the stack is untouched:
  - '[': nest += 1; if nest is already all-ones, set err and go to ERROR.
  - ']' with nest == 0: go to RUN; this op is consumed.
  - ']' with nest != 0: nest -= 1.
  - other op: ignored.
- ERROR: terminal until rst. err = 1, op_ready = 0, stack outputs hold.
- jump is registered (1-cycle latency after acceptance). depth and err are registered.
- When op_valid = 0, nothing changes in any state except the JUMP-to-RUN transition.
- Asserting rst mid-JUMP or mid-SKIP drops jump and skipping immediately (async).

Test Plan:
- After reset, '[' at pc = 0x0005 with cell_zero = 0 -> stk_we = 1, stk_delta = 01, stk_wd = 0x0005 in the acceptance cycle; depth = 1 on the next cycle.
- Then ']' at pc = 0x0009 with cell_zero = 0 and stk_rd = 0x0005 -> no stack action; next cycle jump = 1 for one cycle with jump_pc = 0x0006, op_ready = 0 in that cycle; depth stays 1.
- Then ']' with cell_zero = 1 -> stk_delta = 11, stk_we = 0; depth becomes 0; jump never asserts.
- '[' with cell_zero = 1, then ops '[', '+', ']', ']' -> skipping = 1 throughout. nest goes 1 then back to 0; the final ']' returns to RUN with skipping = 0, and no stk_we or delta is ever seen.
- 17 pushes with DEPTH = 16 -> first 16 push, 17th gives err = 1 with no push; op_ready = 0 until rst; after rst, depth = 0 and err = 0.
- ']' at depth = 0 with cell_zero = 0 -> err = 1, no jump, stk_delta = 00; also assert rst during a JUMP cycle -> jump drops to 0 immediately.
